// File: rtl/dot_pkg.sv
// Shared constants and the packer state encoding for the dot-product result packer.
package dot_pkg;

    localparam int NO_OF_UNITS   = 8;
    localparam int ELEMENT_WIDTH = 32;
    localparam int FIFO_DEPTH    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } packer_state_t;

endpackage

// File: rtl/result_fifo.sv
// Word FIFO with a registered head stage. The head register is a copy of the
// oldest stored entry, so an entry occupies its slot until it is popped and the
// total capacity is exactly 'depth' words. 'depth' must be a power of two >= 2.
module result_fifo #(
    parameter int width = 257,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop_ready,
    output logic             full,
    output logic             empty,
    output logic [width-1:0] head_data,
    output logic             head_valid
);

    localparam int AW = $clog2(depth);
    localparam int CW = $clog2(depth) + 1;

    logic [width-1:0] mem_r [depth];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_next_s;
    logic [CW-1:0]    count_r;
    logic [width-1:0] head_data_r;
    logic             head_valid_r;
    logic             pop_s;
    logic             full_s;
    logic             wr_en_s;

    // Handshake decode: a push into a full FIFO only lands when the head leaves on the same edge.
    always_comb begin
        pop_s     = head_valid_r & pop_ready;
        full_s    = (count_r == CW'(depth));
        wr_en_s   = push & (~full_s | pop_s);
        rd_next_s = rd_ptr_r + AW'(1);
    end

    // Storage array write port; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_next_s;
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head register: refill from entries already stored before this edge, so a
    // word pushed into an empty FIFO shows up one clock after its push edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_data_r  <= '0;
            head_valid_r <= 1'b0;
        end else if (pop_s) begin
            if (count_r > CW'(1)) begin
                head_data_r  <= mem_r[rd_next_s];
                head_valid_r <= 1'b1;
            end else begin
                head_valid_r <= 1'b0;
            end
        end else if (!head_valid_r && (count_r != CW'(0))) begin
            head_data_r  <= mem_r[rd_ptr_r];
            head_valid_r <= 1'b1;
        end
    end

    assign full       = full_s;
    assign empty      = (count_r == CW'(0));
    assign head_data  = head_data_r;
    assign head_valid = head_valid_r;

endmodule

// File: rtl/dot_result_packer.sv
// Collects dot-product results, one per rising edge of 'finish', into words of
// no_of_units lanes (first result in the MSB lane) and streams them out through
// a small FIFO with valid/ready handshake, a last tag and a completion pulse.
module dot_result_packer
    import dot_pkg::*;
#(
    parameter int no_of_units   = NO_OF_UNITS,
    parameter int element_width = ELEMENT_WIDTH,
    parameter int fifo_depth    = FIFO_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [31:0]                          no_of_rows,
    input  logic                                 finish,
    input  logic [element_width-1:0]             dot_product_output,
    output logic [element_width*no_of_units-1:0] out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_last,
    output logic                                 done,
    output logic                                 overflow
);

    localparam int DW = element_width * no_of_units;

    packer_state_t  state_r;
    logic [31:0]    rows_r;
    logic [31:0]    row_cnt_r;
    logic [31:0]    lane_r;
    logic [DW-1:0]  word_r;
    logic           finish_q_r;
    logic           done_r;
    logic           overflow_r;

    logic           rise_s;
    logic           accept_s;
    logic [31:0]    cnt_next_s;
    logic           at_end_s;
    logic           push_s;
    logic           last_s;
    logic [DW-1:0]  next_word_s;
    logic           pop_s;
    logic           drop_s;

    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic [DW:0]    fifo_head_s;
    logic           fifo_valid_s;

    // Result acceptance, lane insertion and push decision for the current cycle.
    always_comb begin
        rise_s     = finish & ~finish_q_r;
        accept_s   = (state_r == COLLECT) & rise_s;
        cnt_next_s = row_cnt_r + 32'd1;
        at_end_s   = (cnt_next_s == rows_r);
        push_s     = accept_s & ((lane_r == 32'(no_of_units - 1)) | at_end_s);
        last_s     = accept_s & at_end_s;
        pop_s      = fifo_valid_s & out_ready;
        drop_s     = push_s & fifo_full_s & ~pop_s;
        next_word_s = word_r;
        for (int i = 0; i < no_of_units; i++) begin
            if (lane_r == 32'(i)) begin
                next_word_s[element_width*(no_of_units-i)-1 -: element_width] = dot_product_output;
            end else begin
                next_word_s[element_width*(no_of_units-i)-1 -: element_width] =
                    word_r[element_width*(no_of_units-i)-1 -: element_width];
            end
        end
    end

    // Control FSM with the finish edge register, counters, partial word and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            rows_r     <= 32'd0;
            row_cnt_r  <= 32'd0;
            lane_r     <= 32'd0;
            word_r     <= '0;
            finish_q_r <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            finish_q_r <= finish;
            done_r     <= 1'b0;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (no_of_rows == 32'd0) begin
                            done_r <= 1'b1;
                        end else begin
                            rows_r    <= no_of_rows;
                            row_cnt_r <= 32'd0;
                            lane_r    <= 32'd0;
                            word_r    <= '0;
                            state_r   <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (accept_s) begin
                        row_cnt_r <= cnt_next_s;
                        if (push_s) begin
                            word_r <= '0;
                            lane_r <= 32'd0;
                        end else begin
                            word_r <= next_word_s;
                            lane_r <= lane_r + 32'd1;
                        end
                        if (last_s) begin
                            state_r <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop_s && fifo_head_s[DW]) begin
                        state_r <= IDLE;
                        done_r  <= 1'b1;
                    end else if (fifo_empty_s) begin
                        // The last-tagged word was dropped on overflow; nothing left to wait for.
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    result_fifo #(
        .width (DW + 1),
        .depth (fifo_depth)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .push_data  ({last_s, next_word_s}),
        .pop_ready  (out_ready),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .head_data  (fifo_head_s),
        .head_valid (fifo_valid_s)
    );

    assign out_data  = fifo_head_s[DW-1:0];
    assign out_last  = fifo_head_s[DW];
    assign out_valid = fifo_valid_s;
    assign done      = done_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_dot_result_packer.sv
// Directed, table-driven bench for dot_result_packer with default parameters.
module tb_dot_result_packer;

    logic         clk;
    logic         reset;
    logic         start;
    logic [31:0]  no_of_rows;
    logic         finish;
    logic [31:0]  dot_product_output;
    logic [255:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         done;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [256:0] got_q [$];
    int cyc          = 0;
    int done_cnt     = 0;
    int done_cyc     = -1;
    int last_pop_cyc = -100;
    bit valid_seen   = 1'b0;

    typedef struct {
        int           rows;
        logic [31:0]  base;
        int           nwords;
        logic [255:0] w0;
        logic [255:0] w1;
        logic         l0;
        logic         l1;
    } vec_t;

    vec_t vecs [4];

    dot_result_packer dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .no_of_rows         (no_of_rows),
        .finish             (finish),
        .dot_product_output (dot_product_output),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_last           (out_last),
        .done               (done),
        .overflow           (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the output side away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                got_q.push_back({out_last, out_data});
                if (out_last) last_pop_cyc = cyc;
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (out_valid) valid_seen = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [256:0] act, input logic [256:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [256:0] word_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return '0;
    endfunction

    function automatic logic [255:0] seq_word(input logic [31:0] b, input int k);
        logic [255:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) w[255-32*j -: 32] = b + 32'(8*k + j);
        return w;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs;
        got_q.delete();
        done_cnt     = 0;
        done_cyc     = -1;
        last_pop_cyc = -100;
        valid_seen   = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] rows);
        no_of_rows = rows;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic send_result(input logic [31:0] d);
        dot_product_output = d;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        tick();
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && done_cnt == 0; i++) tick();
        repeat (3) tick();
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        clear_obs();
        out_ready = 1'b1;
        do_start(v.rows);
        for (int i = 0; i < v.rows; i++) send_result(v.base + 32'(i));
        wait_done(60);
        check({tag, " nwords"}, 257'(got_q.size()), 257'(v.nwords));
        check({tag, " word0"}, word_at(0), {v.l0, v.w0});
        for (int k = 1; k < v.nwords; k++) check({tag, " word1"}, word_at(1), {v.l1, v.w1});
        check({tag, " done count"}, 257'(done_cnt), 257'd1);
        check({tag, " done timing"}, 257'(done_cyc), 257'(last_pop_cyc + 1));
        check({tag, " overflow"}, 257'(overflow), 257'd0);
    endtask

    initial begin
        vecs[0] = '{8, 32'h3F800000, 1,
                    {32'h3F800000, 32'h3F800001, 32'h3F800002, 32'h3F800003,
                     32'h3F800004, 32'h3F800005, 32'h3F800006, 32'h3F800007},
                    256'h0, 1'b1, 1'b0};
        vecs[1] = '{11, 32'h3F800000, 2,
                    {32'h3F800000, 32'h3F800001, 32'h3F800002, 32'h3F800003,
                     32'h3F800004, 32'h3F800005, 32'h3F800006, 32'h3F800007},
                    {32'h3F800008, 32'h3F800009, 32'h3F80000A, 160'h0},
                    1'b0, 1'b1};
        vecs[2] = '{3, 32'hDEAD0000, 1,
                    {32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 160'h0},
                    256'h0, 1'b1, 1'b0};
        vecs[3] = '{9, 32'h00000010, 2,
                    {32'h00000010, 32'h00000011, 32'h00000012, 32'h00000013,
                     32'h00000014, 32'h00000015, 32'h00000016, 32'h00000017},
                    {32'h00000018, 224'h0},
                    1'b0, 1'b1};

        reset = 1'b1; start = 1'b0; no_of_rows = 32'd0; finish = 1'b0;
        dot_product_output = 32'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", 257'(out_valid), 257'd0);
        check("reset out_last", 257'(out_last), 257'd0);
        check("reset done", 257'(done), 257'd0);
        check("reset overflow", 257'(overflow), 257'd0);
        check("reset out_data", 257'(out_data), 257'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick();

        // Table-driven vectors with out_ready held high.
        for (int v = 0; v < 4; v++) run_vector(vecs[v], $sformatf("vec%0d", v));

        // Finish held high: only two rising edges count.
        clear_obs();
        out_ready = 1'b1;
        do_start(32'd2);
        dot_product_output = 32'hAAAA0001;
        finish = 1'b1;
        tick();
        dot_product_output = 32'hBAD0BAD0;
        repeat (4) tick();
        finish = 1'b0;
        tick();
        dot_product_output = 32'hAAAA0002;
        finish = 1'b1;
        tick();
        dot_product_output = 32'hBAD1BAD1;
        repeat (2) tick();
        finish = 1'b0;
        wait_done(30);
        check("held finish nwords", 257'(got_q.size()), 257'd1);
        check("held finish word", word_at(0), {1'b1, 32'hAAAA0001, 32'hAAAA0002, 192'h0});

        // Push-to-valid latency and stability under backpressure.
        clear_obs();
        out_ready = 1'b0;
        do_start(32'd1);
        dot_product_output = 32'h12345678;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        @(negedge clk);
        check("latency valid low on push cycle", 257'(out_valid), 257'd0);
        @(negedge clk);
        check("latency valid one clock later", 257'(out_valid), 257'd1);
        repeat (3) @(negedge clk);
        check("stall valid held", 257'(out_valid), 257'd1);
        check("stall data held", {out_last, out_data}, {1'b1, 32'h12345678, 224'h0});
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done(20);
        check("latency word", word_at(0), {1'b1, 32'h12345678, 224'h0});
        check("latency done count", 257'(done_cnt), 257'd1);

        // Zero-row start: done next cycle, no word.
        clear_obs();
        do_start(32'd0);
        @(negedge clk);
        check("zero rows done pulse", 257'(done), 257'd1);
        @(negedge clk);
        check("zero rows done drop", 257'(done), 257'd0);
        repeat (5) tick();
        check("zero rows no valid", 257'(valid_seen), 257'd0);
        check("zero rows done count", 257'(done_cnt), 257'd1);

        // Overflow: 48 rows with no consumer, fifth word lost.
        clear_obs();
        out_ready = 1'b0;
        do_start(32'd48);
        for (int i = 0; i < 48; i++) begin
            send_result(32'h10000000 + 32'(i));
            if (i == 31) check("overflow clear at 4 words", 257'(overflow), 257'd0);
            if (i == 39) check("overflow set at 5th word", 257'(overflow), 257'd1);
        end
        check("overflow sticky", 257'(overflow), 257'd1);
        check("overflow head word", {out_last, out_data}, {1'b0, seq_word(32'h10000000, 0)});
        out_ready = 1'b1;
        repeat (20) tick();
        check("overflow delivered count", 257'(got_q.size()), 257'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("overflow word%0d", k), word_at(k), {1'b0, seq_word(32'h10000000, k)});
        check("overflow fifo drained", 257'(out_valid), 257'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("overflow cleared by reset", 257'(overflow), 257'd0);

        // Reset in mid-vector discards everything, then normal operation resumes.
        clear_obs();
        out_ready = 1'b0;
        do_start(32'd16);
        for (int i = 0; i < 10; i++) send_result(32'h50000000 + 32'(i));
        #2;
        reset = 1'b1;
        #1;
        check("midreset out_valid", 257'(out_valid), 257'd0);
        check("midreset out_data", 257'(out_data), 257'd0);
        check("midreset out_last", 257'(out_last), 257'd0);
        check("midreset done", 257'(done), 257'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick();
        check("midreset no done", 257'(done_cnt), 257'd0);
        run_vector(vecs[0], "after reset");

        // Finish already high when reset releases is not an edge.
        reset = 1'b1;
        finish = 1'b1;
        dot_product_output = 32'hBADBAD00;
        tick();
        reset = 1'b0;
        clear_obs();
        out_ready = 1'b1;
        do_start(32'd1);
        repeat (3) tick();
        check("held through reset no word", 257'(valid_seen), 257'd0);
        finish = 1'b0;
        tick();
        send_result(32'hCAFE0001);
        wait_done(20);
        check("held through reset word", word_at(0), {1'b1, 32'hCAFE0001, 224'h0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_result_packer.md
DOT_RESULT_PACKER -- requirements
Module: dot_result_packer

Interface
REQ-001 Parameter no_of_units, default 8, SHALL set the number of 32-bit result lanes per output word.
REQ-002 Parameter element_width, default 32, SHALL set the bit width of one dot-product result.
REQ-003 Parameter fifo_depth, default 4, SHALL set the number of output words buffered, as a power of two.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that latches no_of_rows and begins a vector.
REQ-007 no_of_rows  input  32  number of dot-product results expected for this vector.
REQ-008 finish  input  1  level completion flag from the dot-product unit; each rising edge marks one new result.
REQ-009 dot_product_output  input  element_width  result value, valid in the cycle where the finish rising edge is detected.
REQ-010 out_data  output  element_width*no_of_units  packed result word.
REQ-011 out_valid  output  1  out_data holds a valid word.
REQ-012 out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high.
REQ-013 out_last  output  1  the word currently presented is the final word of the vector.
REQ-014 done  output  1  one-cycle pulse after the last word has been accepted.
REQ-015 overflow  output  1  sticky error flag: a completed word was dropped because the FIFO was full.

Function
REQ-016 Control SHALL be an FSM with states IDLE, COLLECT and DRAIN.
REQ-017 IDLE -> COLLECT on start with no_of_rows > 0; no_of_rows is latched, and the lane index and row counter are cleared.
REQ-018 Start with no_of_rows == 0 SHALL pulse done on the next cycle, stay in IDLE and push no word.
REQ-019 Start outside IDLE SHALL be ignored.
REQ-020 finish SHALL be registered one cycle; a result is accepted only on finish==1 with previous finish==0, and only in COLLECT.
REQ-021 An accepted result SHALL be written to lane k, bits [element_width*(no_of_units-k)-1 -: element_width], so the first result lands in the MSB lane.
REQ-022 When lane no_of_units-1 is written, or the row counter reaches no_of_rows, the word SHALL be pushed into the FIFO on that same edge.
  - Unwritten lanes in the pushed word SHALL be zero.
  - The lane index SHALL then wrap to 0.
REQ-023 The word holding result no_of_rows SHALL be pushed with its last tag set, and the FSM SHALL move COLLECT -> DRAIN.
REQ-024 Latency: out_valid SHALL rise one clock after the edge that pushes a word into an empty FIFO.
REQ-025 out_data, out_last and out_valid SHALL come directly from the FIFO head and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 Push and pop in the same cycle with the FIFO full SHALL both succeed and the occupancy SHALL stay unchanged.
REQ-027 A push into a full FIFO with no simultaneous pop SHALL:
  - drop the word;
  - set overflow until reset;
  - still advance the row count.
REQ-028 DRAIN -> IDLE when the last-tagged word is popped; done SHALL pulse high for exactly one cycle on the following edge.
REQ-029 The row counter and lane index SHALL be 32 bits wide; result values SHALL pass through unmodified, with no arithmetic applied.

Reset
REQ-030 Reset SHALL force:
  - FSM to IDLE;
  - FIFO empty and pointers 0;
  - lane index, row counter and latched no_of_rows to 0;
  - registered finish to 0;
  - out_valid, out_last, done and overflow to 0;
  - out_data to 0.
REQ-031 Reset during COLLECT or DRAIN SHALL discard every partial or buffered word with no done pulse.
REQ-032 After reset deassertion, finish already held high SHALL NOT count as a rising edge.

Structure
REQ-033 A shared package dot_pkg SHALL hold:
  - NO_OF_UNITS=8, ELEMENT_WIDTH=32, FIFO_DEPTH=4;
  - the packer state enum (IDLE, COLLECT, DRAIN).
REQ-034 The FIFO SHALL be a separate sub-module result_fifo (width element_width*no_of_units+1, depth fifo_depth, registered head).

Verification
REQ-035 no_of_rows=8, results 0x3F800000..0x3F800007 each on a fresh finish rise, out_ready=1 -> one word with MSB lane 0x3F800000 and LSB lane 0x3F800007; out_last=1; done one cycle after the pop.
REQ-036 no_of_rows=11 -> two words: the second holds lanes 0-2 = results 9-11 and lanes 3-7 = 0; out_last on the second word only.
REQ-037 finish held high for 5 cycles, then low for 1 cycle, then high -> exactly 2 results accepted.
REQ-038 no_of_rows=48, out_ready=0 throughout -> 4 words buffered, overflow=1 after the 5th word, that word lost; then out_ready=1 -> words 1-4 delivered intact.
REQ-039 no_of_rows=16, reset asserted after 10 results -> all outputs 0 immediately; a new start with no_of_rows=8 operates normally.
REQ-040 start with no_of_rows=0 -> done high exactly one cycle later; out_valid never asserted.
